// File: rtl/MemoryController_Definitions.sv
// Shared memory-controller types: DDR4 command encoding and sequencer FSM states.
package MemoryController_Definitions;

   typedef enum logic [2:0] {
      CMD_NOP = 3'd0,
      CMD_ACT = 3'd1,
      CMD_RD  = 3'd2,
      CMD_WR  = 3'd3,
      CMD_PRE = 3'd4,
      CMD_REF = 3'd5
   } cmd_e;

   typedef enum logic [3:0] {
      ST_IDLE         = 4'd0,
      ST_PRE          = 4'd1,
      ST_WAIT_RP      = 4'd2,
      ST_ACT          = 4'd3,
      ST_WAIT_RCD     = 4'd4,
      ST_CAS          = 4'd5,
      ST_REF_PREA     = 4'd6,
      ST_REF_WAIT_RP  = 4'd7,
      ST_REF_CMD      = 4'd8,
      ST_REF_WAIT_RFC = 4'd9
   } state_e;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/open_row_table.sv
// Open-row tracker: one {valid, row} entry per rank/bank-group/bank with
// combinational lookup, synchronous set/clear and a global invalidate.
module open_row_table #(
   parameter int unsigned IW     = 6,
   parameter int unsigned RWIDTH = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [IW-1:0]     i_lkp_idx,
   output logic              o_lkp_valid_c,
   output logic [RWIDTH-1:0] o_lkp_row_c,
   input  logic [IW-1:0]     i_wr_idx,
   input  logic              i_set,
   input  logic [RWIDTH-1:0] i_set_row,
   input  logic              i_clr,
   input  logic              i_clr_all
);
   localparam int unsigned ENTRIES = 1 << IW;

   logic [ENTRIES-1:0] r_valid;
   logic [RWIDTH-1:0]  r_row [ENTRIES];

   assign o_lkp_valid_c = r_valid[i_lkp_idx];
   assign o_lkp_row_c   = r_row[i_lkp_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
      end else if (i_clr_all) begin
         r_valid <= '0;
      end else if (i_set) begin
         r_valid[i_wr_idx] <= 1'b1;
      end else if (i_clr) begin
         r_valid[i_wr_idx] <= 1'b0;
      end
   end

   // Row contents are meaningless while the valid bit is clear, so no reset.
   always_ff @(posedge clk) begin
      if (i_set) begin
         r_row[i_wr_idx] <= i_set_row;
      end
   end

endmodule

// File: rtl/ddr4_cmd_sequencer.sv
// DDR4 command sequencer: turns accepted read/write requests into PRE/ACT/CAS
// sequences under an open-page policy and inserts periodic all-rank refresh.
module ddr4_cmd_sequencer
   import MemoryController_Definitions::*;
#(
   parameter int unsigned NUMRANK = 4,
   parameter int unsigned RWIDTH  = 15,
   parameter int unsigned CWIDTH  = 10,
   parameter int unsigned BGWIDTH = 2,
   parameter int unsigned BKWIDTH = 2,
   parameter int unsigned tRCD    = 16,
   parameter int unsigned tRP     = 16,
   parameter int unsigned tRFC    = 256,
   parameter int unsigned tREFI   = 6240
) (
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic                                          req_valid,
   output logic                                          req_ready,
   input  logic                                          req_write,
   input  logic [$clog2(NUMRANK)-1:0]                    req_rank,
   input  logic [BGWIDTH-1:0]                            req_bg,
   input  logic [BKWIDTH-1:0]                            req_bk,
   input  logic [RWIDTH-1:0]                             req_row,
   input  logic [CWIDTH-1:0]                             req_col,
   output logic                                          cmd_valid,
   output cmd_e                                          cmd_type,
   output logic [$clog2(NUMRANK)-1:0]                    cmd_rank,
   output logic [BGWIDTH-1:0]                            cmd_bg,
   output logic [BKWIDTH-1:0]                            cmd_bk,
   output logic [((RWIDTH > CWIDTH) ? RWIDTH : CWIDTH)-1:0] cmd_addr,
   output logic                                          done,
   output logic                                          done_write
);
   localparam int unsigned RKW = $clog2(NUMRANK);
   localparam int unsigned AW  = (RWIDTH > CWIDTH) ? RWIDTH : CWIDTH;
   localparam int unsigned IW  = RKW + BGWIDTH + BKWIDTH;
   localparam int unsigned WCW = $clog2(max_u(max_u(tRP, tRCD), tRFC));
   localparam int unsigned RCW = $clog2(tREFI);

   state_e              r_state, w_state_nxt;
   logic [WCW-1:0]      r_wcnt, w_wcnt_nxt;
   logic [RKW-1:0]      r_ridx, w_ridx_nxt;
   logic [RCW-1:0]      r_ref_cnt;
   logic                r_pending, w_pending_nxt, w_pending_clr, w_ref_wrap;
   logic                r_ready, w_accept;

   logic                r_write;
   logic [RKW-1:0]      r_rank;
   logic [BGWIDTH-1:0]  r_bg;
   logic [BKWIDTH-1:0]  r_bk;
   logic [RWIDTH-1:0]   r_row;
   logic [CWIDTH-1:0]   r_col;

   logic                w_lkp_valid;
   logic [RWIDTH-1:0]   w_lkp_row;
   logic                w_tbl_set, w_tbl_clr, w_tbl_clr_all;

   logic                r_cmd_valid, w_cmd_valid;
   cmd_e                r_cmd_type, w_cmd_type;
   logic [RKW-1:0]      r_cmd_rank, w_cmd_rank;
   logic [BGWIDTH-1:0]  r_cmd_bg, w_cmd_bg;
   logic [BKWIDTH-1:0]  r_cmd_bk, w_cmd_bk;
   logic [AW-1:0]       r_cmd_addr, w_cmd_addr;
   logic                r_done, w_done, r_done_write, w_done_write;

   assign w_accept   = req_valid && r_ready;
   assign w_ref_wrap = (r_ref_cnt == RCW'(tREFI - 1));

   open_row_table #(
      .IW     (IW),
      .RWIDTH (RWIDTH)
   ) u_open_row_table (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_lkp_idx     ({req_rank, req_bg, req_bk}),
      .o_lkp_valid_c (w_lkp_valid),
      .o_lkp_row_c   (w_lkp_row),
      .i_wr_idx      ({r_rank, r_bg, r_bk}),
      .i_set         (w_tbl_set),
      .i_set_row     (r_row),
      .i_clr         (w_tbl_clr),
      .i_clr_all     (w_tbl_clr_all)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_wcnt  <= '0;
         r_ridx  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_wcnt  <= w_wcnt_nxt;
         r_ridx  <= w_ridx_nxt;
      end
   end

   // Wait counters load tX-2 on the command cycle so the next command lands tX later.
   always_comb begin
      w_state_nxt   = r_state;
      w_wcnt_nxt    = r_wcnt;
      w_ridx_nxt    = r_ridx;
      w_cmd_valid   = 1'b0;
      w_cmd_type    = CMD_NOP;
      w_cmd_rank    = '0;
      w_cmd_bg      = '0;
      w_cmd_bk      = '0;
      w_cmd_addr    = '0;
      w_done        = 1'b0;
      w_done_write  = 1'b0;
      w_tbl_set     = 1'b0;
      w_tbl_clr     = 1'b0;
      w_tbl_clr_all = 1'b0;
      w_pending_clr = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_pending) begin
               w_state_nxt = ST_REF_PREA;
               w_ridx_nxt  = '0;
            end else if (w_accept) begin
               if (!w_lkp_valid)              w_state_nxt = ST_ACT;
               else if (w_lkp_row == req_row) w_state_nxt = ST_CAS;
               else                           w_state_nxt = ST_PRE;
            end
         end
         ST_PRE: begin
            w_cmd_valid = 1'b1;
            w_cmd_type  = CMD_PRE;
            w_cmd_rank  = r_rank;
            w_cmd_bg    = r_bg;
            w_cmd_bk    = r_bk;
            w_tbl_clr   = 1'b1;
            w_wcnt_nxt  = WCW'(tRP - 2);
            w_state_nxt = ST_WAIT_RP;
         end
         ST_WAIT_RP: begin
            if (r_wcnt == '0) w_state_nxt = ST_ACT;
            else              w_wcnt_nxt  = r_wcnt - WCW'(1);
         end
         ST_ACT: begin
            w_cmd_valid = 1'b1;
            w_cmd_type  = CMD_ACT;
            w_cmd_rank  = r_rank;
            w_cmd_bg    = r_bg;
            w_cmd_bk    = r_bk;
            w_cmd_addr  = AW'(r_row);
            w_tbl_set   = 1'b1;
            w_wcnt_nxt  = WCW'(tRCD - 2);
            w_state_nxt = ST_WAIT_RCD;
         end
         ST_WAIT_RCD: begin
            if (r_wcnt == '0) w_state_nxt = ST_CAS;
            else              w_wcnt_nxt  = r_wcnt - WCW'(1);
         end
         ST_CAS: begin
            w_cmd_valid  = 1'b1;
            w_cmd_type   = r_write ? CMD_WR : CMD_RD;
            w_cmd_rank   = r_rank;
            w_cmd_bg     = r_bg;
            w_cmd_bk     = r_bk;
            w_cmd_addr   = AW'(r_col);
            w_done       = 1'b1;
            w_done_write = r_write;
            w_state_nxt  = ST_IDLE;
         end
         ST_REF_PREA: begin
            w_cmd_valid    = 1'b1;
            w_cmd_type     = CMD_PRE;
            w_cmd_rank     = r_ridx;
            w_cmd_addr[10] = 1'b1;
            if (r_ridx == RKW'(NUMRANK - 1)) begin
               w_ridx_nxt  = '0;
               w_wcnt_nxt  = WCW'(tRP - 2);
               w_state_nxt = ST_REF_WAIT_RP;
            end else begin
               w_ridx_nxt  = r_ridx + RKW'(1);
            end
         end
         ST_REF_WAIT_RP: begin
            if (r_wcnt == '0) w_state_nxt = ST_REF_CMD;
            else              w_wcnt_nxt  = r_wcnt - WCW'(1);
         end
         ST_REF_CMD: begin
            w_cmd_valid = 1'b1;
            w_cmd_type  = CMD_REF;
            w_cmd_rank  = r_ridx;
            if (r_ridx == RKW'(NUMRANK - 1)) begin
               w_ridx_nxt  = '0;
               w_wcnt_nxt  = WCW'(tRFC - 2);
               w_state_nxt = ST_REF_WAIT_RFC;
            end else begin
               w_ridx_nxt  = r_ridx + RKW'(1);
            end
         end
         ST_REF_WAIT_RFC: begin
            if (r_wcnt == '0) begin
               w_pending_clr = 1'b1;
               w_tbl_clr_all = 1'b1;
               w_state_nxt   = ST_IDLE;
            end else begin
               w_wcnt_nxt    = r_wcnt - WCW'(1);
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // A fresh expiry outranks the end-of-refresh clear: pending just stays set.
   always_comb begin
      w_pending_nxt = r_pending;
      if (w_ref_wrap)         w_pending_nxt = 1'b1;
      else if (w_pending_clr) w_pending_nxt = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ref_cnt <= '0;
         r_pending <= 1'b0;
         r_ready   <= 1'b0;
      end else begin
         r_ref_cnt <= w_ref_wrap ? '0 : r_ref_cnt + RCW'(1);
         r_pending <= w_pending_nxt;
         r_ready   <= (w_state_nxt == ST_IDLE) && !w_pending_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_write <= 1'b0;
         r_rank  <= '0;
         r_bg    <= '0;
         r_bk    <= '0;
         r_row   <= '0;
         r_col   <= '0;
      end else if (w_accept) begin
         r_write <= req_write;
         r_rank  <= req_rank;
         r_bg    <= req_bg;
         r_bk    <= req_bk;
         r_row   <= req_row;
         r_col   <= req_col;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cmd_valid  <= 1'b0;
         r_cmd_type   <= CMD_NOP;
         r_cmd_rank   <= '0;
         r_cmd_bg     <= '0;
         r_cmd_bk     <= '0;
         r_cmd_addr   <= '0;
         r_done       <= 1'b0;
         r_done_write <= 1'b0;
      end else begin
         r_cmd_valid  <= w_cmd_valid;
         r_cmd_type   <= w_cmd_type;
         r_cmd_rank   <= w_cmd_rank;
         r_cmd_bg     <= w_cmd_bg;
         r_cmd_bk     <= w_cmd_bk;
         r_cmd_addr   <= w_cmd_addr;
         r_done       <= w_done;
         r_done_write <= w_done_write;
      end
   end

   assign req_ready  = r_ready;
   assign cmd_valid  = r_cmd_valid;
   assign cmd_type   = r_cmd_type;
   assign cmd_rank   = r_cmd_rank;
   assign cmd_bg     = r_cmd_bg;
   assign cmd_bk     = r_cmd_bk;
   assign cmd_addr   = r_cmd_addr;
   assign done       = r_done;
   assign done_write = r_done_write;

endmodule

// File: tb/tb_ddr4_cmd_sequencer.sv
// Scoreboard bench for ddr4_cmd_sequencer: expected commands are queued with
// their issue cycle when a request is accepted or a refresh is due.
module tb_ddr4_cmd_sequencer;
   import MemoryController_Definitions::*;

   localparam int unsigned NR     = 4;
   localparam int unsigned T_RCD  = 16;
   localparam int unsigned T_RP   = 16;
   localparam int unsigned T_RFC  = 256;
   localparam int unsigned T_REFI = 1000;

   logic        clk, rst_n;
   logic        req_valid, req_ready, req_write;
   logic [1:0]  req_rank, req_bg, req_bk;
   logic [14:0] req_row;
   logic [9:0]  req_col;
   logic        cmd_valid;
   cmd_e        cmd_type;
   logic [1:0]  cmd_rank, cmd_bg, cmd_bk;
   logic [14:0] cmd_addr;
   logic        done, done_write;

   typedef struct {
      int unsigned cyc;
      cmd_e        typ;
      logic [1:0]  rank, bg, bk;
      logic [14:0] addr;
      logic        dn;
      logic        dw;
      logic        chk_dw;
   } exp_t;

   exp_t        q_exp[$];
   int unsigned n_total = 0;
   int unsigned n_bad   = 0;
   int unsigned cyc;
   logic        m_valid [64];
   logic [14:0] m_row   [64];

   ddr4_cmd_sequencer #(
      .NUMRANK(NR), .RWIDTH(15), .CWIDTH(10), .BGWIDTH(2), .BKWIDTH(2),
      .tRCD(T_RCD), .tRP(T_RP), .tRFC(T_RFC), .tREFI(T_REFI)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_rank(req_rank), .req_bg(req_bg), .req_bk(req_bk),
      .req_row(req_row), .req_col(req_col),
      .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_rank(cmd_rank),
      .cmd_bg(cmd_bg), .cmd_bk(cmd_bk), .cmd_addr(cmd_addr),
      .done(done), .done_write(done_write)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h (cyc=%0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic void push(input int unsigned c, input cmd_e t, input logic [1:0] rk,
                                input logic [1:0] bg, input logic [1:0] bk, input logic [14:0] a,
                                input logic dn, input logic dw, input logic cdw);
      exp_t e;
      e.cyc = c; e.typ = t; e.rank = rk; e.bg = bg; e.bk = bk;
      e.addr = a; e.dn = dn; e.dw = dw; e.chk_dw = cdw;
      q_exp.push_back(e);
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < 64; i++) begin
         m_valid[i] = 1'b0;
         m_row[i]   = '0;
      end
   endfunction

   // Monitor: every command cycle must match the head of the queue.
   always @(negedge clk) begin
      if (rst_n) begin
         if (cmd_valid) begin
            if (q_exp.size() == 0) begin
               check_eq("unexp_cmd", 64'(cmd_valid), 64'd0);
            end else begin
               exp_t e;
               e = q_exp.pop_front();
               check_eq("cmd_cyc",  64'(cyc),      64'(e.cyc));
               check_eq("cmd_type", 64'(cmd_type), 64'(e.typ));
               check_eq("cmd_rank", 64'(cmd_rank), 64'(e.rank));
               check_eq("cmd_bg",   64'(cmd_bg),   64'(e.bg));
               check_eq("cmd_bk",   64'(cmd_bk),   64'(e.bk));
               check_eq("cmd_addr", 64'(cmd_addr), 64'(e.addr));
               check_eq("done",     64'(done),     64'(e.dn));
               if (e.chk_dw) check_eq("done_write", 64'(done_write), 64'(e.dw));
            end
         end else begin
            check_eq("idle_out", 64'({cmd_type, cmd_rank, cmd_bg, cmd_bk, cmd_addr, done}), 64'd0);
         end
      end
   end

   // Called at a negedge; returns the accept edge number (0 on timeout).
   task automatic do_req(input logic wr, input logic [1:0] rk, input logic [1:0] bg,
                         input logic [1:0] bk, input logic [14:0] row, input logic [9:0] col,
                         output int unsigned t_acc);
      int unsigned idx;
      bit          got;
      cmd_e        cas;
      req_valid = 1'b1; req_write = wr; req_rank = rk; req_bg = bg; req_bk = bk;
      req_row = row; req_col = col;
      got = 1'b0;
      t_acc = 0;
      for (int i = 0; i < 2000 && !got; i++) begin
         if (req_ready) got = 1'b1;
         else @(negedge clk);
      end
      if (!got) begin
         check_eq("accept_timeout", 64'(req_ready), 64'd1);
         req_valid = 1'b0;
         return;
      end
      t_acc = cyc + 1;
      idx = {rk, bg, bk};
      cas = wr ? CMD_WR : CMD_RD;
      if (!m_valid[idx]) begin
         push(t_acc + 1, CMD_ACT, rk, bg, bk, row, 1'b0, 1'b0, 1'b0);
         push(t_acc + 1 + T_RCD, cas, rk, bg, bk, 15'(col), 1'b1, wr, 1'b1);
         m_valid[idx] = 1'b1;
         m_row[idx]   = row;
      end else if (m_row[idx] == row) begin
         push(t_acc + 1, cas, rk, bg, bk, 15'(col), 1'b1, wr, 1'b1);
      end else begin
         push(t_acc + 1, CMD_PRE, rk, bg, bk, 15'd0, 1'b0, 1'b0, 1'b0);
         push(t_acc + 1 + T_RP, CMD_ACT, rk, bg, bk, row, 1'b0, 1'b0, 1'b0);
         push(t_acc + 1 + T_RP + T_RCD, cas, rk, bg, bk, 15'(col), 1'b1, wr, 1'b1);
         m_row[idx] = row;
      end
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int unsigned guard;
      guard = 0;
      while (q_exp.size() != 0 && guard < 400) begin
         @(negedge clk);
         guard++;
      end
      check_eq("drain", 64'(q_exp.size()), 64'd0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: bench did not finish (cyc=%0d)", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int unsigned t, e, g;
      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
      req_rank = '0; req_bg = '0; req_bk = '0; req_row = '0; req_col = '0;
      model_clear();
      repeat (3) @(negedge clk);
      check_eq("rst_ready", 64'(req_ready), 64'd0);
      check_eq("rst_outs", 64'({cmd_valid, cmd_type, cmd_rank, cmd_bg, cmd_bk, cmd_addr, done, done_write}), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("ready_after_rst", 64'(req_ready), 64'd1);

      // Closed bank, row hit, row miss with write, then extra patterns.
      do_req(1'b0, 2'd0, 2'd1, 2'd2, 15'h1234, 10'h008, t);
      check_eq("first_accept", 64'(t), 64'd2);
      wait_drain();
      do_req(1'b0, 2'd0, 2'd1, 2'd2, 15'h1234, 10'h010, t);
      wait_drain();
      do_req(1'b1, 2'd0, 2'd1, 2'd2, 15'h0055, 10'h020, t);
      wait_drain();
      do_req(1'b1, 2'd3, 2'd3, 2'd3, 15'h7fff, 10'h3ff, t);
      wait_drain();
      do_req(1'b0, 2'd3, 2'd3, 2'd3, 15'h7fff, 10'h000, t);
      wait_drain();
      do_req(1'b0, 2'd2, 2'd0, 2'd0, 15'h0000, 10'h155, t);
      wait_drain();

      // Refresh expiry with a request arriving as pending rises.
      g = 0;
      while (cyc < T_REFI - 1 && g < 3000) begin @(negedge clk); g++; end
      check_eq("ready_pre_ref", 64'(req_ready), 64'd1);
      @(negedge clk);
      check_eq("ready_at_ref", 64'(req_ready), 64'd0);
      e = T_REFI;
      for (int r = 0; r < NR; r++)
         push(e + 2 + r, CMD_PRE, 2'(r), 2'd0, 2'd0, 15'h0400, 1'b0, 1'b0, 1'b0);
      for (int r = 0; r < NR; r++)
         push(e + 2 + (NR - 1) + T_RP + r, CMD_REF, 2'(r), 2'd0, 2'd0, 15'd0, 1'b0, 1'b0, 1'b0);
      model_clear();
      do_req(1'b0, 2'd0, 2'd1, 2'd2, 15'h0055, 10'h0ab, t);
      check_eq("accept_after_ref", 64'(t), 64'(e + 2 + (NR - 1) + T_RP + (NR - 1) + T_RFC));
      wait_drain();

      // Reset in the middle of an ACT->CAS wait.
      do_req(1'b0, 2'd1, 2'd0, 2'd3, 15'h0777, 10'h011, t);
      repeat (5) @(negedge clk);
      check_eq("q_before_rst", 64'(q_exp.size()), 64'd1);
      rst_n = 1'b0;
      #1;
      check_eq("rst_mid_outs", 64'({cmd_valid, cmd_type, cmd_rank, cmd_bg, cmd_bk, cmd_addr, done, done_write}), 64'd0);
      check_eq("rst_mid_ready", 64'(req_ready), 64'd0);
      q_exp.delete();
      model_clear();
      repeat (20) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("ready_after_rst2", 64'(req_ready), 64'd1);
      do_req(1'b0, 2'd1, 2'd0, 2'd3, 15'h0777, 10'h011, t);
      wait_drain();
      repeat (30) @(negedge clk);
      check_eq("final_queue", 64'(q_exp.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/ddr4_cmd_sequencer.md
DDR4_CMD_SEQUENCER -- requirements
Module: ddr4_cmd_sequencer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): NUMRANK, 4, ranks per channel.
REQ-002 The block SHALL have the parameter RWIDTH, default 15, row address width.
REQ-003 The block SHALL have the parameter CWIDTH, default 10, column address width.
REQ-004 The block SHALL have the parameters BGWIDTH, default 2, and BKWIDTH, default 2, giving the bank-group and bank address widths.
REQ-005 The block SHALL have the parameters tRCD, default 16, and tRP, default 16, both in clk cycles.
REQ-006 The block SHALL have the parameters tRFC, default 256, and tREFI, default 6240, both in clk cycles.
REQ-007 The block SHALL have these ports (name, direction, width, meaning): clk, in, 1, single clock; rst_n, in, 1, reset, asynchronous, active-low.
REQ-008 req_valid, in, 1, and req_ready, out, 1, form the request handshake; req_write, in, 1, selects 1=write, 0=read.
REQ-009 The request address inputs SHALL be req_rank (in, $clog2(NUMRANK)), req_bg (in, BGWIDTH), req_bk (in, BKWIDTH), req_row (in, RWIDTH) and req_col (in, CWIDTH).
REQ-010 cmd_valid, out, 1, marks a command cycle; cmd_type, out, cmd_e, is one of NOP/ACT/RD/WR/PRE/REF.
REQ-011 The command address outputs SHALL be cmd_rank, cmd_bg, cmd_bk and cmd_addr, with cmd_addr of width max(RWIDTH,CWIDTH), carrying the row for ACT and the column for RD/WR.
REQ-012 done, out, 1, SHALL pulse in the CAS cycle of a request; done_write, out, 1, SHALL carry the latched req_write.

Function
REQ-013 An accept SHALL occur on a clk edge where req_valid && req_ready; all req_* fields SHALL be latched on accept.
REQ-014 req_ready SHALL be 1 only when the FSM is in IDLE and refresh_pending = 0.
REQ-015 All command outputs SHALL be registered; cmd_type = NOP, cmd_valid = 0 and all address fields = 0 whenever no command is issued.
REQ-016 The FSM states SHALL be IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, CAS, REF_PREA, REF_WAIT_RP, REF_CMD and REF_WAIT_RFC.
REQ-017 On accept, the FSM SHALL go to CAS on a row hit (bank open, same row), to PRE on a row miss (bank open, different row), and to ACT if the bank is closed.
REQ-018 Command timing relative to an accept at edge T: a row hit SHALL issue RD/WR at T+1.
REQ-019 A closed bank SHALL issue ACT at T+1 and CAS at T+1+tRCD.
REQ-020 A row miss SHALL issue PRE at T+1, ACT at T+1+tRP and CAS at T+1+tRP+tRCD.
REQ-021 The wait counters SHALL load (tX-2) on the command cycle and exit the wait state on reaching 0, so the next command lands exactly tX cycles later.
REQ-022 The block SHALL use an open-page policy: ACT SHALL mark the bank open with its row, PRE SHALL mark it closed, and CAS SHALL leave it open.
REQ-023 The open-row table SHALL hold NUMRANK*2^(BGWIDTH+BKWIDTH) entries, each {valid, row}.
REQ-024 A refresh counter SHALL count clk cycles from 0 and, on reaching tREFI-1, set refresh_pending and wrap to 0.
REQ-025 If the counter reaches tREFI-1 again while refresh is pending, pending SHALL stay 1 (no postponement count).
REQ-026 The refresh sequence SHALL run from IDLE with pending=1: PRE to ranks 0..NUMRANK-1 on consecutive cycles (cmd_bg/cmd_bk = 0, cmd_addr[10] = 1 for all-bank), then wait tRP after the last PRE.
REQ-027 After the tRP wait, the block SHALL issue REF to ranks 0..NUMRANK-1 on consecutive cycles, then wait tRFC after the last REF, then clear pending, invalidate the whole table and return to IDLE.
REQ-028 If refresh becomes pending in the same cycle as req_valid in IDLE, refresh SHALL win: req_ready = 0 and no accept occurs.
REQ-029 A request already accepted SHALL complete before refresh starts.
REQ-030 done SHALL be a 1-cycle pulse coincident with cmd_type = RD/WR; read data return is outside this block.

Reset
REQ-031 On rst_n = 0, at any state, the block SHALL force: FSM = IDLE, cmd_valid = 0, cmd_type = NOP, address fields = 0, done = 0, done_write = 0, wait counters = 0, refresh counter = 0, refresh_pending = 0, all table valid bits = 0.
REQ-032 req_ready SHALL be 0 while rst_n = 0 and 1 in the first cycle after release.

Structure
REQ-033 cmd_e and the FSM state enum SHALL live in the shared MemoryController_Definitions package.
REQ-034 The open-row table SHALL be one sub-module, open_row_table: combinational lookup, with synchronous set and clear plus a clear-all input.

Verification
REQ-035 Empty table, read of rank0/bg1/bk2/row 0x1234/col 0x008 accepted at T -> ACT row 0x1234 at T+1, RD col 0x008 with done = 1 at T+17.
REQ-036 Then a read of the same bank, row 0x1234, col 0x010 -> RD at T'+1, with no ACT.
REQ-037 Then a write to the same bank, row 0x0055, col 0x020 -> PRE at T+1, ACT 0x0055 at T+17, WR at T+33, done_write = 1.
REQ-038 With tREFI = 1000: PRE r0..r3 on consecutive cycles at expiry, REF r0..r3 16 cycles after the last PRE, and req_ready = 0 until 256 cycles after the last REF; a later access to bg1/bk2 issues ACT, not PRE.
REQ-039 req_valid asserted on the cycle refresh_pending rises -> no accept; the request is accepted in the first IDLE cycle after REF_WAIT_RFC.
REQ-040 rst_n pulsed low during WAIT_RCD -> outputs NOP at once, no CAS issued, and a following request to the same bank issues ACT.
